// File: rtl/xing_sched_pkg.sv
// Shared definitions for the crossing scheduler: one-hot state indices, lamp codes, helpers.
// Defining XING_SCHED_PED_EN adds the WALK state and widens the state vector by one bit.
package xing_sched_pkg;

    localparam int S_IDLE = 0;
    localparam int S_AG   = 1;
    localparam int S_AY   = 2;
    localparam int S_AR   = 3;
    localparam int S_BG   = 4;
    localparam int S_BY   = 5;
`ifdef XING_SCHED_PED_EN
    localparam int S_WALK  = 6;
    localparam int STATE_W = 7;
`else
    localparam int STATE_W = 6;
`endif

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    localparam state_t STATE_ZERO = '0;

    function automatic state_t state_bit(input int idx);
        return STATE_ZERO | (state_t'(1) << idx);
    endfunction

endpackage

// File: rtl/xing_sched_phase_timer.sv
// Phase timer: saturating up-counter with synchronous clear and terminal compare.
// Count is registered; tc_o compares the registered count against term_i combinationally.
module xing_sched_phase_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/xing_sched.sv
// Two-approach crossing scheduler: one-hot FSM with min/max green, yellow and all-red clearance.
// Outputs decode from registered state only; XING_SCHED_PED_EN adds the pedestrian WALK phase.
module xing_sched
    import xing_sched_pkg::*;
#(
    parameter int unsigned G_MIN  = 8,
    parameter int unsigned G_MAX  = 32,
    parameter int unsigned Y_CYC  = 4,
    parameter int unsigned AR_CYC = 2,
    parameter int unsigned W_CYC  = 16,
    parameter int unsigned CNT_W  = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               req_a,
    input  logic               req_b,
`ifdef XING_SCHED_PED_EN
    input  logic               ped_req,
    output logic               walk,
`endif
    output logic [1:0]         lamp_a,
    output logic [1:0]         lamp_b,
    output logic [STATE_W-1:0] phase
);

    if (G_MIN < 1 || G_MAX < G_MIN || Y_CYC < 1 || AR_CYC < 1 || W_CYC < 1 ||
        G_MAX > 2**CNT_W || Y_CYC > 2**CNT_W || AR_CYC > 2**CNT_W || W_CYC > 2**CNT_W) begin : g_cfg_err
        $error("xing_sched: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(G_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(G_MAX - 1);
    localparam logic [CNT_W-1:0] T_Y    = CNT_W'(Y_CYC - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(AR_CYC - 1);

    localparam state_t ST_IDLE = state_bit(S_IDLE);
    localparam state_t ST_AG   = state_bit(S_AG);
    localparam state_t ST_AY   = state_bit(S_AY);
    localparam state_t ST_AR   = state_bit(S_AR);
    localparam state_t ST_BG   = state_bit(S_BG);
    localparam state_t ST_BY   = state_bit(S_BY);

    state_t           state_q, state_d, ar_grant;
    logic             last_grant_q, last_grant_d;   // 1 = B was granted last
    logic             ped_pend;
    logic [CNT_W-1:0] cnt, term;
    logic             tc, tmr_clr, green_min;

`ifdef XING_SCHED_PED_EN
    localparam logic [CNT_W-1:0] T_W = CNT_W'(W_CYC - 1);
    localparam state_t ST_WALK = state_bit(S_WALK);

    logic ped_pend_q, ped_pend_d;

    // A request landing on the WALK-entry cycle must not be lost.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (clr) begin
            ped_pend_d = 1'b0;
        end else if (ped_req) begin
            ped_pend_d = 1'b1;
        end else if (state_d[S_WALK] && !state_q[S_WALK]) begin
            ped_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end

    assign ped_pend = ped_pend_q;
`else
    assign ped_pend = 1'b0;
`endif

    always_comb begin
        term = T_GMAX;
        if (state_q[S_AY] || state_q[S_BY]) begin
            term = T_Y;
        end else if (state_q[S_AR]) begin
            term = T_AR;
`ifdef XING_SCHED_PED_EN
        end else if (state_q[S_WALK]) begin
            term = T_W;
`endif
        end
    end

    // Every state change (and any clr) restarts the phase count from zero.
    assign tmr_clr   = clr || (state_d != state_q);
    assign green_min = (cnt >= T_GMIN);

    xing_sched_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_i  (tmr_clr),
        .term_i (term),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    always_comb begin
        ar_grant = ST_IDLE;
        if (last_grant_q ? req_a : req_b) begin
            ar_grant = last_grant_q ? ST_AG : ST_BG;
        end else if (last_grant_q ? req_b : req_a) begin
            ar_grant = last_grant_q ? ST_BG : ST_AG;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (1'b1)
                state_q[S_IDLE]: begin
                    if (req_a && (!req_b || last_grant_q)) state_d = ST_AG;
                    else if (req_b)                        state_d = ST_BG;
                end
                state_q[S_AG]: if (tc || (green_min && (req_b || ped_pend))) state_d = ST_AY;
                state_q[S_AY]: if (tc) state_d = ST_AR;
                state_q[S_BG]: if (tc || (green_min && (req_a || ped_pend))) state_d = ST_BY;
                state_q[S_BY]: if (tc) state_d = ST_AR;
                state_q[S_AR]: begin
                    if (tc) begin
`ifdef XING_SCHED_PED_EN
                        state_d = ped_pend ? ST_WALK : ar_grant;
`else
                        state_d = ar_grant;
`endif
                    end
                end
`ifdef XING_SCHED_PED_EN
                state_q[S_WALK]: if (tc) state_d = ST_AR;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_d[S_AG] && !state_q[S_AG]) begin
            last_grant_d = 1'b0;
        end else if (state_d[S_BG] && !state_q[S_BG]) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        lamp_a = LAMP_RED;
        lamp_b = LAMP_RED;
        if (state_q[S_AG]) lamp_a = LAMP_GREEN;
        if (state_q[S_AY]) lamp_a = LAMP_YELLOW;
        if (state_q[S_BG]) lamp_b = LAMP_GREEN;
        if (state_q[S_BY]) lamp_b = LAMP_YELLOW;
`ifdef XING_SCHED_PED_EN
        walk = state_q[S_WALK];
`endif
        phase = state_q;
    end

endmodule
